seq_divider_8: RTL

SEQ_DIVIDER_8 -- requirements
Module: seq_divider_8

---
 rtl/seq_divider_8_pkg.sv | 13 +
 rtl/seq_divider_8_div_step.sv | 24 ++
 rtl/seq_divider_8.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_divider_8_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and the controller state encoding.
package seq_divider_8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_8_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // The top bit of trial is the borrow of the subtraction, i.e. the quotient bit inverted.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider_8.sv
// Sequential unsigned divider: one restoring step per clock, results and the
// divide-by-zero flag registered on entry to the one-cycle DONE state.
module seq_divider_8
  import seq_divider_8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs_r;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem_acc),
    .dividend_bit(dvd_sh[WIDTH-1]),
    .divisor     (dvs_r),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  // dvd_sh starts as the dividend and fills with quotient bits from the LSB,
  // so after WIDTH steps it holds the complete quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      rem_acc   <= '0;
      dvd_sh    <= '0;
      dvs_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          busy <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            count   <= '0;
            rem_acc <= '0;
            dvd_sh  <= dividend;
            dvs_r   <= divisor;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (dvs_r == '0) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= '1;
            remainder <= dvd_sh;
            dbz       <= 1'b1;
          end else if (count == LAST_COUNT) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= dvd_sh;
            remainder <= rem_acc[WIDTH-1:0];
            dbz       <= 1'b0;
          end else begin
            busy    <= 1'b1;
            rem_acc <= step_rem;
            dvd_sh  <= (dvd_sh << 1) | WIDTH'(step_q);
            count   <= count + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
